mem_stage_hs: RTL and testbench

- Parametrised successor of the single-cycle MEM stage: the same MEM/WB pipeline register plus an LSU front end that talks to an external data bus through a req/ack handshake, so memories and peripherals may take any number of cycles.
- Generates byte enables and store-lane replication, formats load data (sign/zero extension), detects misaligned accesses, and back-pressures EX while a bus transaction is outstanding.
- Sits between the EX/MEM register and the WB stage; the hazard unit consumes mem_ready_o.

---
 rtl/mem_stage_hs.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM stage with a req/ack data-bus front end and the MEM/WB register.
// Ports: EX/MEM inputs ex_*; the data bus dbus_*; the MEM/WB outputs wb_*; and the status
//   pulses misalign_o and bus_err_o. mem_ready_o backpressures EX while a transfer is outstanding.
// Latency: 1 cycle for non-memory ops and rejected accesses; at least 2 cycles for loads/stores.
// Optional MEM_TIMEOUT_EN: bus-ack watchdog that aborts after TIMEOUT_CYC BUS cycles.
module mem_stage_hs #(
  parameter int ADDR_W      = 32,
  parameter int WB_EN_W     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               ex_valid_i,
  output logic               mem_ready_o,
  input  logic               flush_i,
  input  logic [31:0]        ex_alu_i,
  input  logic [31:0]        ex_rs2_i,
  input  logic [4:0]         ex_rd_addr_i,
  input  logic [31:0]        ex_pc_four_i,
  input  logic               ex_rd_wren_i,
  input  logic [WB_EN_W-1:0] ex_wb_en_i,
  input  logic               ex_mem_rd_i,
  input  logic               ex_mem_wr_i,
  input  logic [2:0]         ex_mem_op_i,
  output logic               dbus_req_o,
  output logic               dbus_we_o,
  output logic [ADDR_W-1:0]  dbus_addr_o,
  output logic [3:0]         dbus_be_o,
  output logic [31:0]        dbus_wdata_o,
  input  logic               dbus_ack_i,
  input  logic [31:0]        dbus_rdata_i,
  output logic               misalign_o,
  output logic               bus_err_o,
  output logic               wb_valid_o,
  output logic [31:0]        wb_alu_o,
  output logic [31:0]        wb_ld_o,
  output logic [31:0]        wb_pc_four_o,
  output logic [4:0]         wb_rd_addr_o,
  output logic               wb_rd_wren_o,
  output logic [WB_EN_W-1:0] wb_wb_en_o
);

  typedef enum logic {S_IDLE = 1'b0, S_BUS = 1'b1} state_e;

  state_e state_q, state_d;

  // Instruction held while its bus transfer is outstanding.
  logic [31:0]        hold_alu_q, hold_alu_d, hold_pc4_q, hold_pc4_d;
  logic [4:0]         hold_rd_q, hold_rd_d;
  logic               hold_wren_q, hold_wren_d, hold_ld_q, hold_ld_d, hold_kill_q, hold_kill_d;
  logic [2:0]         hold_op_q, hold_op_d;
  logic [WB_EN_W-1:0] hold_wben_q, hold_wben_d;

  logic               dbus_req_q, dbus_req_d, dbus_we_q, dbus_we_d;
  logic [ADDR_W-1:0]  dbus_addr_q, dbus_addr_d;
  logic [3:0]         dbus_be_q, dbus_be_d;
  logic [31:0]        dbus_wdata_q, dbus_wdata_d;

  logic               wb_valid_q, wb_valid_d, wb_rd_wren_q, wb_rd_wren_d;
  logic [31:0]        wb_alu_q, wb_alu_d, wb_ld_q, wb_ld_d, wb_pc4_q, wb_pc4_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [WB_EN_W-1:0] wb_wben_q, wb_wben_d;
  logic               misalign_q, misalign_d, bus_err_q, bus_err_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  // Access decode for the incoming instruction. op[1:0]: 00 byte, 01 half, else word
  // (undefined codes fall into word).
  logic        ex_mis;
  logic [3:0]  ex_be;
  logic [31:0] ex_wdata;
  always_comb begin
    ex_mis   = 1'b0;
    ex_be    = 4'b1111;
    ex_wdata = ex_rs2_i;
    case (ex_mem_op_i[1:0])
      2'b00: begin
        ex_be    = 4'b0001 << ex_alu_i[1:0];
        ex_wdata = {4{ex_rs2_i[7:0]}};
      end
      2'b01: begin
        ex_mis   = ex_alu_i[0];
        ex_be    = ex_alu_i[1] ? 4'b1100 : 4'b0011;
        ex_wdata = {2{ex_rs2_i[15:0]}};
      end
      default: ex_mis = (ex_alu_i[1:0] != 2'b00);
    endcase
  end

  // Load lane select and extension for the held access.
  logic [31:0] ld_shift, ld_fmt;
  always_comb begin
    ld_shift = dbus_rdata_i >> {hold_alu_q[1:0], 3'b000};
    case (hold_op_q)
      3'b000:  ld_fmt = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_fmt = {24'h0, ld_shift[7:0]};
      3'b001:  ld_fmt = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_fmt = {16'h0, ld_shift[15:0]};
      default: ld_fmt = ld_shift;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hold_alu_d   = hold_alu_q;
    hold_pc4_d   = hold_pc4_q;
    hold_rd_d    = hold_rd_q;
    hold_wren_d  = hold_wren_q;
    hold_ld_d    = hold_ld_q;
    hold_kill_d  = hold_kill_q;
    hold_op_d    = hold_op_q;
    hold_wben_d  = hold_wben_q;
    dbus_req_d   = dbus_req_q;
    dbus_we_d    = dbus_we_q;
    dbus_addr_d  = dbus_addr_q;
    dbus_be_d    = dbus_be_q;
    dbus_wdata_d = dbus_wdata_q;
    // WB defaults to a bubble every cycle.
    wb_valid_d   = 1'b0;
    wb_alu_d     = '0;
    wb_ld_d      = '0;
    wb_pc4_d     = '0;
    wb_rd_d      = '0;
    wb_rd_wren_d = 1'b0;
    wb_wben_d    = '0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        dbus_req_d = 1'b0;
        if (ex_valid_i && !flush_i) begin
          if (ex_mem_rd_i || ex_mem_wr_i) begin
            if (ex_mis) begin
              // Rejected access retires without a register write.
              misalign_d = 1'b1;
              wb_valid_d = 1'b1;
              wb_alu_d   = ex_alu_i;
              wb_pc4_d   = ex_pc_four_i;
              wb_rd_d    = ex_rd_addr_i;
              wb_wben_d  = ex_wb_en_i;
            end else begin
              state_d      = S_BUS;
              hold_alu_d   = ex_alu_i;
              hold_pc4_d   = ex_pc_four_i;
              hold_rd_d    = ex_rd_addr_i;
              hold_wren_d  = ex_rd_wren_i;
              hold_ld_d    = ex_mem_rd_i && !ex_mem_wr_i;
              hold_kill_d  = 1'b0;
              hold_op_d    = ex_mem_op_i;
              hold_wben_d  = ex_wb_en_i;
              dbus_req_d   = 1'b1;
              dbus_we_d    = ex_mem_wr_i;
              dbus_addr_d  = {ex_alu_i[ADDR_W-1:2], 2'b00};
              dbus_be_d    = ex_be;
              dbus_wdata_d = ex_wdata;
`ifdef MEM_TIMEOUT_EN
              cnt_d        = '0;
`endif
            end
          end else begin
            wb_valid_d   = 1'b1;
            wb_alu_d     = ex_alu_i;
            wb_pc4_d     = ex_pc_four_i;
            wb_rd_d      = ex_rd_addr_i;
            wb_rd_wren_d = ex_rd_wren_i;
            wb_wben_d    = ex_wb_en_i;
          end
        end
      end
      S_BUS: begin
        // A flush cannot tear the transfer; it only suppresses the write-back.
        hold_kill_d = hold_kill_q | flush_i;
        if (dbus_ack_i) begin
          state_d      = S_IDLE;
          dbus_req_d   = 1'b0;
          wb_valid_d   = !hold_kill_d;
          wb_alu_d     = hold_alu_q;
          wb_ld_d      = hold_ld_q ? ld_fmt : 32'h0;
          wb_pc4_d     = hold_pc4_q;
          wb_rd_d      = hold_rd_q;
          wb_rd_wren_d = hold_wren_q && hold_ld_q && !hold_kill_d;
          wb_wben_d    = hold_wben_q;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d    = S_IDLE;
          dbus_req_d = 1'b0;
          bus_err_d  = 1'b1;
          wb_valid_d = 1'b1;
          wb_alu_d   = hold_alu_q;
          wb_pc4_d   = hold_pc4_q;
          wb_rd_d    = hold_rd_q;
          wb_wben_d  = hold_wben_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_alu_q   <= '0;
      hold_pc4_q   <= '0;
      hold_rd_q    <= '0;
      hold_wren_q  <= 1'b0;
      hold_ld_q    <= 1'b0;
      hold_kill_q  <= 1'b0;
      hold_op_q    <= '0;
      hold_wben_q  <= '0;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_be_q    <= '0;
      dbus_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_alu_q     <= '0;
      wb_ld_q      <= '0;
      wb_pc4_q     <= '0;
      wb_rd_q      <= '0;
      wb_rd_wren_q <= 1'b0;
      wb_wben_q    <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_alu_q   <= hold_alu_d;
      hold_pc4_q   <= hold_pc4_d;
      hold_rd_q    <= hold_rd_d;
      hold_wren_q  <= hold_wren_d;
      hold_ld_q    <= hold_ld_d;
      hold_kill_q  <= hold_kill_d;
      hold_op_q    <= hold_op_d;
      hold_wben_q  <= hold_wben_d;
      dbus_req_q   <= dbus_req_d;
      dbus_we_q    <= dbus_we_d;
      dbus_addr_q  <= dbus_addr_d;
      dbus_be_q    <= dbus_be_d;
      dbus_wdata_q <= dbus_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_alu_q     <= wb_alu_d;
      wb_ld_q      <= wb_ld_d;
      wb_pc4_q     <= wb_pc4_d;
      wb_rd_q      <= wb_rd_d;
      wb_rd_wren_q <= wb_rd_wren_d;
      wb_wben_q    <= wb_wben_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign mem_ready_o  = (state_q == S_IDLE);
  assign dbus_req_o   = dbus_req_q;
  assign dbus_we_o    = dbus_we_q;
  assign dbus_addr_o  = dbus_addr_q;
  assign dbus_be_o    = dbus_be_q;
  assign dbus_wdata_o = dbus_wdata_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_alu_o     = wb_alu_q;
  assign wb_ld_o      = wb_ld_q;
  assign wb_pc_four_o = wb_pc4_q;
  assign wb_rd_addr_o = wb_rd_q;
  assign wb_rd_wren_o = wb_rd_wren_q;
  assign wb_wb_en_o   = wb_wben_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
module tb_mem_stage_hs;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, flush_i, ex_rd_wren_i, ex_mem_rd_i, ex_mem_wr_i;
  logic [31:0] ex_alu_i, ex_rs2_i, ex_pc_four_i;
  logic [4:0]  ex_rd_addr_i;
  logic [1:0]  ex_wb_en_i;
  logic [2:0]  ex_mem_op_i;
  logic        mem_ready_o, dbus_req_o, dbus_we_o, dbus_ack_i, misalign_o, bus_err_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_be_o;
  logic        wb_valid_o, wb_rd_wren_o;
  logic [31:0] wb_alu_o, wb_ld_o, wb_pc_four_o;
  logic [4:0]  wb_rd_addr_o;
  logic [1:0]  wb_wb_en_o;

  mem_stage_hs dut (
    .clk_i(clk_i), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .mem_ready_o(mem_ready_o),
    .flush_i(flush_i), .ex_alu_i(ex_alu_i), .ex_rs2_i(ex_rs2_i), .ex_rd_addr_i(ex_rd_addr_i),
    .ex_pc_four_i(ex_pc_four_i), .ex_rd_wren_i(ex_rd_wren_i), .ex_wb_en_i(ex_wb_en_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_wr_i(ex_mem_wr_i), .ex_mem_op_i(ex_mem_op_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .wb_valid_o(wb_valid_o), .wb_alu_o(wb_alu_o), .wb_ld_o(wb_ld_o),
    .wb_pc_four_o(wb_pc_four_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_wren_o(wb_rd_wren_o),
    .wb_wb_en_o(wb_wb_en_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] alu, ld, pc4;
    logic [4:0]  rd;
    logic        wren;
    logic [1:0]  wben;
  } wb_exp_t;

  wb_exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int req_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, and retire any WB output
  // against the oldest expected record.
  task automatic tick();
    wb_exp_t e;
    @(posedge clk_i);
    #1;
    if (wb_valid_o === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL wb_unexpected: observed wb_valid_o=1 alu=0x%08h expected no write-back", wb_alu_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_alu", wb_alu_o, e.alu);
        chk("wb_ld", wb_ld_o, e.ld);
        chk("wb_pc_four", wb_pc_four_o, e.pc4);
        chk("wb_rd_addr", {27'h0, wb_rd_addr_o}, {27'h0, e.rd});
        chk("wb_rd_wren", {31'h0, wb_rd_wren_o}, {31'h0, e.wren});
        chk("wb_wb_en", {30'h0, wb_wb_en_o}, {30'h0, e.wben});
      end
    end
  endtask

  task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic wren, input logic rd_m, input logic wr_m,
                       input logic [2:0] op, input logic [1:0] wben);
    ex_valid_i   = 1'b1;
    ex_alu_i     = alu;
    ex_rs2_i     = rs2;
    ex_pc_four_i = pc4;
    ex_rd_addr_i = rd;
    ex_rd_wren_i = wren;
    ex_mem_rd_i  = rd_m;
    ex_mem_wr_i  = wr_m;
    ex_mem_op_i  = op;
    ex_wb_en_i   = wben;
  endtask

  task automatic accept();
    tick();
    ex_valid_i  = 1'b0;
    ex_mem_rd_i = 1'b0;
    ex_mem_wr_i = 1'b0;
  endtask

  // Hold ack low for n_wait cycles, then ack with rdata; counts cycles with req high.
  task automatic bus_done(input int n_wait, input logic [31:0] rdata, output int rc);
    rc = 0;
    for (int i = 0; i < n_wait; i++) begin
      if (dbus_req_o === 1'b1) rc++;
      tick();
    end
    if (dbus_req_o === 1'b1) rc++;
    dbus_ack_i   = 1'b1;
    dbus_rdata_i = rdata;
    tick();
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'h0;
  endtask

  function automatic wb_exp_t mk(input logic [31:0] alu, input logic [31:0] ld,
                                 input logic [31:0] pc4, input logic [4:0] rd,
                                 input logic wren, input logic [1:0] wben);
    wb_exp_t e;
    e.alu = alu; e.ld = ld; e.pc4 = pc4; e.rd = rd; e.wren = wren; e.wben = wben;
    return e;
  endfunction

  // Aligned memory access: check the bus fields in the first BUS cycle, then complete it.
  task automatic mem_access(input string tag, input logic [31:0] alu, input logic [31:0] rs2,
                            input logic wr, input logic [2:0] op, input int n_wait,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
    issue(alu, rs2, alu + 32'h4, 5'd9, !wr, !wr, wr, op, 2'b01);
    sb.push_back(mk(alu, wr ? 32'h0 : exp_ld, alu + 32'h4, 5'd9, !wr, 2'b01));
    accept();
    chk({tag, "_req"}, {31'h0, dbus_req_o}, 32'h1);
    chk({tag, "_ready"}, {31'h0, mem_ready_o}, 32'h0);
    chk({tag, "_we"}, {31'h0, dbus_we_o}, {31'h0, wr});
    chk({tag, "_addr"}, dbus_addr_o, {alu[31:2], 2'b00});
    chk({tag, "_be"}, {28'h0, dbus_be_o}, {28'h0, exp_be});
    if (wr) chk({tag, "_wdata"}, dbus_wdata_o, exp_wdata);
    bus_done(n_wait, rdata, req_cyc);
    chk({tag, "_req_cycles"}, req_cyc, n_wait + 1);
    chk({tag, "_req_drop"}, {31'h0, dbus_req_o}, 32'h0);
    chk({tag, "_ready_back"}, {31'h0, mem_ready_o}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
    ex_valid_i = 1'b0; ex_alu_i = 32'h0; ex_rs2_i = 32'h0; ex_pc_four_i = 32'h0;
    ex_rd_addr_i = 5'd0; ex_rd_wren_i = 1'b0; ex_mem_rd_i = 1'b0; ex_mem_wr_i = 1'b0;
    ex_mem_op_i = 3'b000; ex_wb_en_i = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_wb_valid", {31'h0, wb_valid_o}, 32'h0);
    chk("rst_req", {31'h0, dbus_req_o}, 32'h0);
    chk("rst_addr", dbus_addr_o, 32'h0);
    chk("rst_be_we", {27'h0, dbus_be_o, dbus_we_o}, 32'h0);
    chk("rst_flags", {30'h0, misalign_o, bus_err_o}, 32'h0);
    chk("rst_ready", {31'h0, mem_ready_o}, 32'h1);
    tick();

    // Non-memory op: one-cycle pass-through.
    issue(32'h0000_1234, 32'h0, 32'h0000_0104, 5'd5, 1'b1, 1'b0, 1'b0, 3'b010, 2'b10);
    sb.push_back(mk(32'h0000_1234, 32'h0, 32'h0000_0104, 5'd5, 1'b1, 2'b10));
    accept();
    chk("add_wb_valid", {31'h0, wb_valid_o}, 32'h1);
    chk("add_ready", {31'h0, mem_ready_o}, 32'h1);

    mem_access("lb",  32'h0000_0103, 32'h0, 1'b0, 3'b000, 3, 32'h80FF_0000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    mem_access("lbu", 32'h0000_0103, 32'h0, 1'b0, 3'b100, 0, 32'h80FF_0000, 4'b1000, 32'h0, 32'h0000_0080);
    mem_access("sh",  32'h0000_0202, 32'hABCD_1234, 1'b1, 3'b001, 1, 32'h0, 4'b1100, 32'h1234_1234, 32'h0);
    mem_access("lh",  32'h0000_0002, 32'h0, 1'b0, 3'b001, 2, 32'h8001_5555, 4'b1100, 32'h0, 32'hFFFF_8001);
    mem_access("lhu", 32'h0000_0000, 32'h0, 1'b0, 3'b101, 0, 32'h1234_F00D, 4'b0011, 32'h0, 32'h0000_F00D);
    mem_access("lw",  32'h0000_0300, 32'h0, 1'b0, 3'b010, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    mem_access("sb",  32'h0000_0001, 32'h1234_565A, 1'b1, 3'b000, 0, 32'h0, 4'b0010, 32'h5A5A_5A5A, 32'h0);
    mem_access("lw_undef_op", 32'h0000_0304, 32'h0, 1'b0, 3'b111, 0, 32'h0BAD_F00D, 4'b1111, 32'h0, 32'h0BAD_F00D);

    // Misaligned word load: rejected, retired without register write.
    issue(32'h0000_0101, 32'h0, 32'h0000_0200, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01);
    sb.push_back(mk(32'h0000_0101, 32'h0, 32'h0000_0200, 5'd3, 1'b0, 2'b01));
    accept();
    chk("mis_pulse", {31'h0, misalign_o}, 32'h1);
    chk("mis_no_req", {31'h0, dbus_req_o}, 32'h0);
    chk("mis_ready", {31'h0, mem_ready_o}, 32'h1);
    tick();
    chk("mis_pulse_end", {31'h0, misalign_o}, 32'h0);

    // Flush in IDLE: bubble.
    issue(32'h0000_7777, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'b010, 2'b00);
    flush_i = 1'b1;
    accept();
    flush_i = 1'b0;
    chk("idle_flush_bubble", {31'h0, wb_valid_o}, 32'h0);

    // Flush during a store's BUS wait: the store still completes, no write-back.
    issue(32'h0000_0400, 32'h0000_0055, 32'h0000_0404, 5'd6, 1'b0, 1'b0, 1'b1, 3'b010, 2'b00);
    accept();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_req_held", {31'h0, dbus_req_o}, 32'h1);
    chk("fl_wdata", dbus_wdata_o, 32'h0000_0055);
    tick();
    chk("fl_req_held2", {31'h0, dbus_req_o}, 32'h1);
    chk("fl_addr_held", dbus_addr_o, 32'h0000_0400);
    dbus_ack_i = 1'b1;
    tick();
    dbus_ack_i = 1'b0;
    chk("fl_req_drop", {31'h0, dbus_req_o}, 32'h0);
    chk("fl_no_wren", {31'h0, wb_rd_wren_o}, 32'h0);
    chk("fl_ready", {31'h0, mem_ready_o}, 32'h1);

    // Reset in the middle of a load transfer.
    issue(32'h0000_0500, 32'h0, 32'h0000_0504, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010, 2'b01);
    accept();
    chk("rb_req", {31'h0, dbus_req_o}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rb_req_drop", {31'h0, dbus_req_o}, 32'h0);
    chk("rb_ready", {31'h0, mem_ready_o}, 32'h1);
    chk("rb_wb_ctl", {28'h0, wb_valid_o, wb_rd_wren_o, wb_wb_en_o}, 32'h0);
    chk("rb_wb_data", wb_alu_o | wb_ld_o | wb_pc_four_o | {27'h0, wb_rd_addr_o}, 32'h0);

    // Ack while IDLE is ignored.
    dbus_ack_i = 1'b1;
    dbus_rdata_i = 32'hFFFF_FFFF;
    tick();
    dbus_ack_i = 1'b0;
    dbus_rdata_i = 32'h0;
    chk("idle_ack_valid", {31'h0, wb_valid_o}, 32'h0);
    chk("idle_ack_req", {31'h0, dbus_req_o}, 32'h0);

    // Stage still works after the mid-transfer reset.
    issue(32'h0000_CAFE, 32'h0, 32'h0000_0600, 5'd31, 1'b1, 1'b0, 1'b0, 3'b000, 2'b11);
    sb.push_back(mk(32'h0000_CAFE, 32'h0, 32'h0000_0600, 5'd31, 1'b1, 2'b11));
    accept();
    tick();

    chk("sb_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
